taint_mul_fifo: RTL and testbench
=================================

Name: taint_mul_fifo

Overview:
Taint-instrumented multiplier with a data-dependent early-out, followed by a parametrised FIFO output buffer. It supersedes the fixed single-slot multiply-then-buffer pair with configurable width, latency and depth, plus ready/valid backpressure on both sides. Every functional signal carries a 1-bit shadow taint (`*_t`). Taint propagates through data paths and through timing/control decisions, for information-flow checking of operand-dependent timing.

Parameters:
- WIDTH, 4: operand width; result is 2*WIDTH.
- MUL_LATENCY, 2: cycles in BUSY for a non-zero multiply (>=1).
- FIFO_DEPTH, 4: output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid / in_valid_t  in  1 / 1  operand-valid and its taint
- in_ready / in_ready_t  out  1 / 1  operand accept and its taint
- in_a / in_a_t  in  WIDTH / 1  operand A and its taint
- in_b / in_b_t  in  WIDTH / 1  operand B and its taint
- out_valid / out_valid_t  out  1 / 1  FIFO non-empty and its taint
- out_ready / out_ready_t  in  1 / 1  consumer ready and its taint
- out_result / out_result_t  out  2*WIDTH / 1  FIFO head and its taint
- count / count_t  out  $clog2(FIFO_DEPTH)+1 / 1  FIFO occupancy and its taint

Behaviour:
- Reset: state IDLE, cnt=0, FIFO empty, all entries and pointers 0, all taint registers 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_result=0, count=0, every *_t=0.
- Multiplier FSM, IDLE:
  - in_ready=1.
  - On in_valid: latch a and b, product = a*b (zero-extended, no truncation), cnt<=1, go to BUSY.
- Multiplier FSM, BUSY:
  - in_ready=0.
  - done = (cnt==MUL_LATENCY) || latched a==0 || latched b==0. The latched operands are used, never the live inputs.
  - done and FIFO not full, or full with a pop this cycle: push product, go to IDLE.
  - done and full with no pop: stall in BUSY; cnt holds.
  - not done: cnt<=cnt+1.
- Latency, with accept in cycle 0 and out_ready=1:
  - zero operand: out_valid in cycle 2;
  - otherwise: out_valid in cycle MUL_LATENCY+1.
  - in_ready returns high in the cycle after the push.
- FIFO:
  - out_valid = count!=0; out_result = head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed when full or empty-to-one; count unchanged on push+pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - count saturates never: push without a pop when full is impossible by construction.
- Taint registers (no clearing except rst):
  - op_t <= in_a_t|in_b_t on accept; it travels with the product as the entry's data taint.
  - mt (multiplier timing taint) is set when:
    - accept occurs and in_valid_t;
    - done is evaluated in BUSY and op_t;
    - a stall/no-stall decision is taken while ft.
  - ft (FIFO control taint) is set when:
    - a push occurs while mt;
    - a pop decision is taken (out_valid=1) while out_ready_t.
- Taint outputs:
  - in_ready_t = mt.
  - out_valid_t = ft; count_t = ft.
  - out_result_t = head entry taint; 0 when empty.
  - Each FIFO entry stores its data taint bit alongside its data.
- Reset mid-operation: the multiply is abandoned, FIFO is flushed, and all taint is cleared on the next edge.

Optional Feature:
- Macro: TAINT_MUL_CONST_TIME_EN.
- Defined:
  - Early-out is removed; done = (cnt==MUL_LATENCY) always.
  - The done evaluation no longer consumes op_t, so operand taint never reaches mt, in_ready_t, out_valid_t or count_t.
  - out_result_t still carries it.
- Undefined: early-out and the op_t→mt rule apply as above.

Decomposition:
- Package taint_mul_pkg holds:
  - state enum {IDLE, BUSY};
  - localparam for the count width, $clog2(FIFO_DEPTH)+1;
  - localparam for the result width, 2*WIDTH.
- Sub-module taint_fifo holds the data array, per-entry taint, pointers, count and ft logic.
  - ft is the FIFO control-taint register; it takes mt as an input and exports full plus ft.
- The FSM lives in the top module.

Test Plan:
1. Functional multiply: a=3, b=5, all taint 0, out_ready=1, accept in cycle 0 → out_result=15 with out_valid in cycle 3; every *_t=0.
2. Early-out with tainted operand: a=0, b=7, in_a_t=1 → out_valid in cycle 2 with result 0, out_result_t=1. From the first BUSY cycle in_ready_t=1, and out_valid_t=1 once the push occurs. With TAINT_MUL_CONST_TIME_EN defined → out_valid in cycle 3, in_ready_t=out_valid_t=0, out_result_t=1.
3. Backpressure: out_ready=0, issue 5 untainted multiplies (2×3 … 2×7), FIFO_DEPTH=4 → count reaches 4 and the 5th stalls in BUSY with in_ready=0. Raising out_ready drains 6, 8, 10, 12, 14 in order with no loss or duplication.
4. Tainted consumer: out_ready_t=1 while out_valid=1 → out_valid_t=count_t=1 from the next cycle. With the FIFO full and a multiply done, in_ready_t becomes 1 after the stall decision.
5. Reset mid-operation: rst in the first BUSY cycle of 9×9 with in_a_t=1 → next cycle in_ready=1, count=0, every *_t=0, and no result ever emerges.
6. Simultaneous push/pop while full: FIFO full, multiply done, out_ready=1 → count stays 4, head advances, and the new product is written at the wrapped tail.

Source files
------------

// File: rtl/taint_mul_pkg.sv
// rtl/taint_mul_pkg.sv - shared types and sizing for the taint-tracked multiplier/FIFO
package taint_mul_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_MUL_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int COUNT_W         = $clog2(DEF_FIFO_DEPTH) + 1;
  localparam int RESULT_W        = 2 * DEF_WIDTH;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/taint_fifo.sv
// rtl/taint_fifo.sv - output FIFO with per-entry data taint and control-taint (ft) register
module taint_fifo
  import taint_mul_pkg::*;
#(
  parameter int DW    = RESULT_W,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int CW   = count_width(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_t,
  input  logic          mt,
  input  logic          out_ready,
  input  logic          out_ready_t,
  output logic          out_valid,
  output logic [DW-1:0] out_result,
  output logic          out_result_t,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ft
);

  logic [DW-1:0] mem  [DEPTH];
  logic          tmem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop;

  assign out_valid    = (count != '0);
  assign full         = (count == CW'(DEPTH));
  assign pop          = out_valid && out_ready;
  assign out_result   = mem[rptr];
  assign out_result_t = out_valid && tmem[rptr];

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ft    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]  <= '0;
        tmem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem[wptr]  <= push_data;
        tmem[wptr] <= push_t;
        wptr       <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      ft    <= ft | (push & mt) | (out_valid & out_ready_t);
    end
  end

endmodule

// File: rtl/taint_mul_fifo.sv
// rtl/taint_mul_fifo.sv - taint-tracked early-out multiplier feeding an output FIFO
// Optional constant-time mode: TAINT_MUL_CONST_TIME_EN
module taint_mul_fifo
  import taint_mul_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int RW         = 2 * WIDTH,
  localparam int CW         = count_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_valid_t,
  output logic             in_ready,
  output logic             in_ready_t,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_a_t,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_b_t,
  output logic             out_valid,
  output logic             out_valid_t,
  input  logic             out_ready,
  input  logic             out_ready_t,
  output logic [RW-1:0]    out_result,
  output logic             out_result_t,
  output logic [CW-1:0]    count,
  output logic             count_t
);

  localparam int LW = $clog2(MUL_LATENCY + 1);

  state_t           state;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_t;
  logic             mt;
  logic             mt_now;
  logic             done;
  logic             done_t;
  logic             busy;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             ft;
  logic [RW-1:0]    product;

  assign busy    = (state == BUSY);
  assign accept  = !busy && in_valid;
  assign pop     = out_valid && out_ready;
  assign product = RW'(a_q) * RW'(b_q);

`ifdef TAINT_MUL_CONST_TIME_EN
  assign done   = (cnt == LW'(MUL_LATENCY));
  assign done_t = 1'b0;
`else
  assign done   = (cnt == LW'(MUL_LATENCY)) || (a_q == '0) || (b_q == '0);
  assign done_t = op_t;
`endif

  assign push = busy && done && (!full || pop);

  // Timing taint is visible in the cycle its triggering decision is made.
  assign mt_now = mt | (accept & in_valid_t) | (busy & done_t) | (busy & done & ft);

  assign in_ready    = !busy;
  assign in_ready_t  = mt_now;
  assign out_valid_t = ft;
  assign count_t     = ft;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_t  <= 1'b0;
      mt    <= 1'b0;
    end else begin
      mt <= mt_now;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_t  <= in_a_t | in_b_t;
            cnt   <= LW'(1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            if (!full || pop) state <= IDLE;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  taint_fifo #(
    .DW   (RW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (product),
    .push_t      (op_t),
    .mt          (mt_now),
    .out_ready   (out_ready),
    .out_ready_t (out_ready_t),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_result_t(out_result_t),
    .count       (count),
    .full        (full),
    .ft          (ft)
  );

endmodule

// File: tb/tb_taint_mul_fifo.sv
// tb/tb_taint_mul_fifo.sv - self-checking bench for taint_mul_fifo with a queue reference model
module tb_taint_mul_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid_t, in_ready, in_ready_t;
  logic [3:0] in_a, in_b;
  logic       in_a_t, in_b_t;
  logic       out_valid, out_valid_t, out_ready, out_ready_t;
  logic [7:0] out_result;
  logic       out_result_t;
  logic [2:0] count;
  logic       count_t;

  int tests = 0;
  int fails = 0;

  taint_mul_fifo dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_valid_t(in_valid_t),
    .in_ready(in_ready), .in_ready_t(in_ready_t),
    .in_a(in_a), .in_a_t(in_a_t), .in_b(in_b), .in_b_t(in_b_t),
    .out_valid(out_valid), .out_valid_t(out_valid_t),
    .out_ready(out_ready), .out_ready_t(out_ready_t),
    .out_result(out_result), .out_result_t(out_result_t),
    .count(count), .count_t(count_t)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 0; in_valid_t = 0; in_a = 0; in_b = 0; in_a_t = 0; in_b_t = 0;
    out_ready = 0; out_ready_t = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic at, input logic bt);
    int k;
    k = 0;
    while (!in_ready && k < 30) begin
      tick();
      k++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL issue_ready_timeout got in_ready=%0d want 1", in_ready);
    end
    in_valid = 1; in_a = a; in_b = b; in_a_t = at; in_b_t = bt;
    tick();
    in_valid = 0; in_a_t = 0; in_b_t = 0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0d want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0d want 0", out_valid); end
    tests++; if (out_result !== 8'd0) begin fails++; $display("FAIL rst_out_result got %0d want 0", out_result); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
    tests++;
    if ({in_ready_t, out_valid_t, out_result_t, count_t} !== 4'b0) begin
      fails++; $display("FAIL rst_taints got %b want 0000", {in_ready_t, out_valid_t, out_result_t, count_t});
    end
  endtask

  task automatic test_mul_basic;
    do_reset();
    out_ready = 1;
    in_valid = 1; in_a = 3; in_b = 5;
    tick();
    in_valid = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_c1 got %0d want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_c2 got %0d want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_c3 got %0d want 1", out_valid); end
    tests++; if (out_result !== 8'd15) begin fails++; $display("FAIL basic_result got %0d want 15", out_result); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready_c3 got %0d want 1", in_ready); end
    tests++;
    if ({in_ready_t, out_valid_t, out_result_t, count_t} !== 4'b0) begin
      fails++; $display("FAIL basic_taints got %b want 0000", {in_ready_t, out_valid_t, out_result_t, count_t});
    end
    tick();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL basic_drained got %0d want 0", count); end
  endtask

  task automatic test_early_out;
    do_reset();
    out_ready = 1;
    in_valid = 1; in_a = 0; in_b = 7; in_a_t = 1;
    tick();
    in_valid = 0; in_a_t = 0;
    tick();
`ifdef TAINT_MUL_CONST_TIME_EN
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL early_ct_valid_c2 got %0d want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL early_ct_valid_c3 got %0d want 1", out_valid); end
    tests++; if (out_result !== 8'd0) begin fails++; $display("FAIL early_ct_result got %0d want 0", out_result); end
    tests++; if (out_result_t !== 1'b1) begin fails++; $display("FAIL early_ct_result_t got %0d want 1", out_result_t); end
    tests++; if (in_ready_t !== 1'b0) begin fails++; $display("FAIL early_ct_in_ready_t got %0d want 0", in_ready_t); end
    tests++; if (out_valid_t !== 1'b0) begin fails++; $display("FAIL early_ct_out_valid_t got %0d want 0", out_valid_t); end
`else
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL early_valid_c2 got %0d want 1", out_valid); end
    tests++; if (out_result !== 8'd0) begin fails++; $display("FAIL early_result got %0d want 0", out_result); end
    tests++; if (out_result_t !== 1'b1) begin fails++; $display("FAIL early_result_t got %0d want 1", out_result_t); end
    tests++; if (in_ready_t !== 1'b1) begin fails++; $display("FAIL early_in_ready_t got %0d want 1", in_ready_t); end
    tests++; if (out_valid_t !== 1'b1) begin fails++; $display("FAIL early_out_valid_t got %0d want 1", out_valid_t); end
`endif
  endtask

  task automatic test_backpressure;
    logic [7:0] got [8];
    int n;
    do_reset();
    for (int i = 3; i <= 7; i++) issue(4'd2, 4'(i), 0, 0);
    repeat (4) tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL bp_count_full got %0d want 4", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_in_ready got %0d want 0", in_ready); end
    out_ready = 1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && n < 8) begin got[n] = out_result; n++; end
      tick();
    end
    tests++; if (n != 5) begin fails++; $display("FAIL bp_drain_count got %0d want 5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      tests++;
      if (got[i] !== 8'(2 * (i + 3))) begin
        fails++; $display("FAIL bp_order[%0d] got %0d want %0d", i, got[i], 2 * (i + 3));
      end
    end
  endtask

  task automatic test_tainted_consumer;
    do_reset();
    for (int i = 1; i <= 5; i++) issue(4'd1, 4'(i), 0, 0);
    repeat (4) tick();
    tests++; if (in_ready_t !== 1'b0) begin fails++; $display("FAIL tc_in_ready_t_pre got %0d want 0", in_ready_t); end
    tests++; if (out_valid_t !== 1'b0) begin fails++; $display("FAIL tc_out_valid_t_pre got %0d want 0", out_valid_t); end
    out_ready_t = 1;
    tick();
    out_ready_t = 0;
    tests++; if (out_valid_t !== 1'b1) begin fails++; $display("FAIL tc_out_valid_t got %0d want 1", out_valid_t); end
    tests++; if (count_t !== 1'b1) begin fails++; $display("FAIL tc_count_t got %0d want 1", count_t); end
    tick();
    tests++; if (in_ready_t !== 1'b1) begin fails++; $display("FAIL tc_in_ready_t_stall got %0d want 1", in_ready_t); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL tc_in_ready_stall got %0d want 0", in_ready); end
    tests++; if (out_result_t !== 1'b0) begin fails++; $display("FAIL tc_data_taint got %0d want 0", out_result_t); end
  endtask

  task automatic test_reset_mid;
    int seen;
    do_reset();
    out_ready = 1;
    in_valid = 1; in_a = 9; in_b = 9; in_a_t = 1;
    tick();
    in_valid = 0; in_a_t = 0;
    rst = 1;
    tick();
    rst = 0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_in_ready got %0d want 1", in_ready); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rm_count got %0d want 0", count); end
    tests++;
    if ({in_ready_t, out_valid_t, out_result_t, count_t} !== 4'b0) begin
      fails++; $display("FAIL rm_taints got %b want 0000", {in_ready_t, out_valid_t, out_result_t, count_t});
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen++;
      tick();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rm_no_result got %0d outputs want 0", seen); end
  endtask

  task automatic test_push_pop_full;
    logic [7:0] r [5];
    logic [3:0] a, b;
    logic [7:0] got [8];
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom_range(1, 15));
      b = 4'($urandom_range(1, 15));
      r[i] = 8'(a * b);
      issue(a, b, 0, 0);
    end
    repeat (4) tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ppf_count_pre got %0d want 4", count); end
    tests++; if (out_result !== r[0]) begin fails++; $display("FAIL ppf_head_pre got %0d want %0d", out_result, r[0]); end
    out_ready = 1;
    tick();
    out_ready = 0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ppf_count_post got %0d want 4", count); end
    tests++; if (out_result !== r[1]) begin fails++; $display("FAIL ppf_head_post got %0d want %0d", out_result, r[1]); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ppf_in_ready got %0d want 1", in_ready); end
    out_ready = 1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && n < 8) begin got[n] = out_result; n++; end
      tick();
    end
    tests++; if (n != 4) begin fails++; $display("FAIL ppf_drain_count got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      tests++;
      if (got[i] !== r[i + 1]) begin
        fails++; $display("FAIL ppf_order[%0d] got %0d want %0d", i, got[i], r[i + 1]);
      end
    end
  endtask

  task automatic test_random;
    logic [8:0] q [$];
    logic [8:0] exp;
    int accepted, emitted, c;
    do_reset();
    accepted = 0; emitted = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      in_b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      in_a_t = 1'($urandom_range(0, 1));
      in_b_t = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back({in_a_t | in_b_t, 8'(in_a * in_b)});
        accepted++;
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rnd_spurious got %0d want none", out_result);
        end else begin
          exp = q.pop_front();
          emitted++;
          if ({out_result_t, out_result} !== exp) begin
            fails++; $display("FAIL rnd_out got t=%0d r=%0d want t=%0d r=%0d", out_result_t, out_result, exp[8], exp[7:0]);
          end
        end
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    c = 0;
    while (q.size() != 0 && c < 60) begin
      if (out_valid) begin
        exp = q.pop_front();
        emitted++;
        tests++;
        if ({out_result_t, out_result} !== exp) begin
          fails++; $display("FAIL rnd_drain got t=%0d r=%0d want t=%0d r=%0d", out_result_t, out_result, exp[8], exp[7:0]);
        end
      end
      tick();
      c++;
    end
    tests++; if (emitted != accepted) begin fails++; $display("FAIL rnd_total got %0d want %0d", emitted, accepted); end
    tick();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rnd_final_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_early_out();
    test_backpressure();
    test_tainted_consumer();
    test_reset_mid();
    test_push_pop_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
